// File: rtl/axi_pkg.sv
// Shared AXI encodings and bridge state type for the CPU-to-AXI master bridge.
package axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WREQ  = 3'd3,
        ST_WRESP = 3'd4,
        ST_DONE  = 3'd5
    } bridge_state_e;

    // AXI SIZE encoding for a full-width beat of data_w bits.
    function automatic logic [2:0] size_of(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_master_bridge.sv
// Converts one SRAM-style CPU port into single-outstanding AXI4 master
// transactions: burst reads for line fills, single-beat writes.
module axi_master_bridge
    import axi_pkg::*;
#(
    parameter int              ID_W      = 4,
    parameter logic [ID_W-1:0] MID       = {ID_W{1'b0}},
    parameter int              DATA_W    = 32,
    parameter int              BURST_LEN = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          CS,
    input  logic                          OE,
    input  logic [DATA_W/8-1:0]           WEB,
    input  logic [31:0]                   A,
    input  logic [DATA_W-1:0]             DI,
    output logic [DATA_W-1:0]             DO,
    output logic [BURST_LEN*DATA_W-1:0]   LINE,
    output logic                          Stall,
    output logic                          rDone,
    output logic                          Err,
    output logic [ID_W-1:0]               AWID,
    output logic [31:0]                   AWADDR,
    output logic [3:0]                    AWLEN,
    output logic [2:0]                    AWSIZE,
    output logic [1:0]                    AWBURST,
    output logic                          AWVALID,
    input  logic                          AWREADY,
    output logic [DATA_W-1:0]             WDATA,
    output logic [DATA_W/8-1:0]           WSTRB,
    output logic                          WLAST,
    output logic                          WVALID,
    input  logic                          WREADY,
    input  logic [ID_W-1:0]               BID,
    input  logic [1:0]                    BRESP,
    input  logic                          BVALID,
    output logic                          BREADY,
    output logic [ID_W-1:0]               ARID,
    output logic [31:0]                   ARADDR,
    output logic [3:0]                    ARLEN,
    output logic [2:0]                    ARSIZE,
    output logic [1:0]                    ARBURST,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic [ID_W-1:0]               RID,
    input  logic [DATA_W-1:0]             RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RLAST,
    input  logic                          RVALID,
    output logic                          RREADY
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int OFF_LSB  = $clog2(STRB_W);
    localparam int LINE_LSB = $clog2(BURST_LEN * STRB_W);
    localparam int BW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    bridge_state_e               state_q;
    logic [31:0]                 addr_q;
    logic [DATA_W-1:0]           wdata_q;
    logic [STRB_W-1:0]           wstrb_q;
    logic [BW-1:0]               crit_q;
    logic [BW-1:0]               beat_q;
    logic                        err_acc_q;
    logic [BURST_LEN*DATA_W-1:0] line_q;
    logic [DATA_W-1:0]           do_q;
    logic                        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic                        rdone_q, err_q;

    logic wr_req_s, req_s, rresp_err_s, aw_ok_s, w_ok_s, unused_ids_s;

    assign wr_req_s     = ~&WEB;
    assign req_s        = CS & (wr_req_s | OE);
    assign rresp_err_s  = (RRESP != RESP_OKAY);
    // An address or data channel counts as finished once its valid has dropped
    // or it is handshaking this very cycle.
    assign aw_ok_s      = ~awvalid_q | AWREADY;
    assign w_ok_s       = ~wvalid_q | WREADY;
    assign unused_ids_s = ^{BID, RID, addr_q[OFF_LSB-1:0]};

    // Bridge FSM with registered channel handshake and completion outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= 32'd0;
            wdata_q   <= {DATA_W{1'b0}};
            wstrb_q   <= {STRB_W{1'b0}};
            crit_q    <= {BW{1'b0}};
            beat_q    <= {BW{1'b0}};
            err_acc_q <= 1'b0;
            line_q    <= {(BURST_LEN*DATA_W){1'b0}};
            do_q      <= {DATA_W{1'b0}};
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            rdone_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (CS && wr_req_s) begin
                        addr_q    <= A;
                        wdata_q   <= DI;
                        wstrb_q   <= ~WEB;
                        err_acc_q <= 1'b0;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= ST_WREQ;
                    end else if (CS && OE) begin
                        addr_q    <= A;
                        crit_q    <= BW'((A >> OFF_LSB) & 32'(BURST_LEN - 1));
                        beat_q    <= {BW{1'b0}};
                        err_acc_q <= 1'b0;
                        arvalid_q <= 1'b1;
                        state_q   <= ST_RADDR;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_RADDR: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (RVALID) begin
                        line_q[beat_q*DATA_W +: DATA_W] <= RDATA;
                        beat_q    <= beat_q + 1'b1;
                        err_acc_q <= err_acc_q | rresp_err_s;
                        if (RLAST || (beat_q == LAST_BEAT)) begin
                            // The final beat is not in line_q yet, so forward it.
                            do_q     <= (crit_q == beat_q) ? RDATA
                                                           : line_q[crit_q*DATA_W +: DATA_W];
                            err_q    <= err_acc_q | rresp_err_s;
                            rdone_q  <= 1'b1;
                            rready_q <= 1'b0;
                            state_q  <= ST_DONE;
                        end
                    end
                end
                ST_WREQ: begin
                    if (awvalid_q && AWREADY) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && WREADY) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_ok_s && w_ok_s) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (BVALID) begin
                        err_acc_q <= (BRESP != RESP_OKAY);
                        err_q     <= (BRESP != RESP_OKAY);
                        rdone_q   <= 1'b1;
                        bready_q  <= 1'b0;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rdone_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    bready_q  <= 1'b0;
                    rdone_q   <= 1'b0;
                    err_q     <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall is forced low while reset is held so a lingering CS cannot show through.
    assign Stall = rst & (((state_q == ST_IDLE) & req_s) |
                          ((state_q != ST_IDLE) & (state_q != ST_DONE)));

    assign DO      = do_q;
    assign LINE    = line_q;
    assign rDone   = rdone_q;
    assign Err     = err_q;

    assign AWID    = MID;
    assign AWADDR  = {addr_q[31:OFF_LSB], {OFF_LSB{1'b0}}};
    assign AWLEN   = 4'd0;
    assign AWSIZE  = size_of(DATA_W);
    assign AWBURST = BURST_INCR;
    assign AWVALID = awvalid_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = 1'b1;
    assign WVALID  = wvalid_q;
    assign BREADY  = bready_q;

    assign ARID    = MID;
    assign ARADDR  = {addr_q[31:LINE_LSB], {LINE_LSB{1'b0}}};
    assign ARLEN   = 4'(BURST_LEN - 1);
    assign ARSIZE  = size_of(DATA_W);
    assign ARBURST = BURST_INCR;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;

endmodule

// File: doc/axi_master_bridge.md
# axi_master_bridge

Parametrised successor to the per-port CPU-to-AXI master wrapper. It converts one CPU-side SRAM-style port (CS/OE/WEB/A/DI/DO) into AXI4 master transactions, one outstanding transaction at a time. It adds configurable ID, data width and read-burst length for line fills, a line-buffer output, and error reporting. One instance sits per CPU memory port (IM, DM) inside the CPU wrapper, facing the interconnect.

## Interface
- MID, default 4'd0: constant driven on ARID/AWID.
- ID_W, default 4: AXI ID width.
- DATA_W, default 32: data width, power of two ≥ 32.
- BURST_LEN, default 1: read beats per request (1, 2, 4, 8 or 16); writes are always single-beat.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- CS, OE  in  1  request select / read request.
- WEB  in  DATA_W/8  per-byte write enable, active low.
- A  in  32  byte address.
- DI  in  DATA_W  write data.
- DO  out  DATA_W  requested word.
- LINE  out  BURST_LEN*DATA_W  full burst, beat 0 in the LSBs.
- Stall  out  1  request pending.
- rDone  out  1  one-cycle completion pulse.
- Err  out  1  RRESP/BRESP ≠ OKAY, valid with rDone.
- AXI AW/W/B/AR/R master channels: ID_W IDs, 32-bit addresses, 4-bit LEN, 3-bit SIZE, 2-bit BURST, 2-bit RRESP/BRESP, DATA_W data, DATA_W/8 WSTRB.

## Operation
- States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- IDLE, CS & write (WEB ≠ all-ones): latch A, DI and ~WEB, then go to WREQ. Write takes priority if OE is also set.
- IDLE, CS & OE & no write: latch A, then go to RADDR.
- Otherwise stay in IDLE.
- RADDR: ARVALID=1 with the following fields:
  - ARADDR = A aligned down to BURST_LEN*DATA_W/8 bytes.
  - ARLEN = BURST_LEN-1, ARSIZE = log2(DATA_W/8), ARBURST = INCR.
  - On ARREADY, go to RDATA.
- RDATA: RREADY=1. Each RVALID beat is written into LINE slot beat_cnt, and beat_cnt increments. RRESP ≠ 0 sets err_acc. RLAST (or beat_cnt = BURST_LEN-1) moves to DONE. RID is not checked.
- WREQ: AWVALID and WVALID are asserted together.
  - AWADDR = A aligned to DATA_W/8; AWLEN=0; WLAST=1; WSTRB = latched ~WEB.
  - Each valid drops independently on its own handshake; both flags are tracked.
  - When both handshakes are done, go to WRESP. Same-cycle handshakes are legal.
- WRESP: BREADY=1. On BVALID, capture BRESP into err_acc and go to DONE.
- DONE: rDone=1, Stall=0, Err=err_acc. Return to IDLE; err_acc clears on the next accept.
- DO = LINE slot selected by the latched critical-word offset A[log2(BURST_LEN*DATA_W/8)-1 : log2(DATA_W/8)]. DO and LINE hold until the next read completes.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; every VALID/READY output 0; Stall, rDone, Err 0; DO and LINE 0; counters 0.
- Reset mid-transaction aborts it immediately. No completion is reported.
- Stall is combinational: 1 in IDLE when a request is detected, 1 in all non-IDLE states except DONE.
- Minimum latencies, zero wait states:
  - Read: accept → ARVALID 1 cycle, then BURST_LEN beats, then DONE. Total BURST_LEN+2 cycles.
  - Write: 3 cycles.
- VALIDs, once raised, hold with stable payload until their handshake (AXI rule).
- The CPU advances on the DONE edge. A request still present in IDLE the cycle after DONE is a new request.

## Structure
- Shared package axi_pkg: burst/resp encodings (INCR, OKAY, SLVERR, DECERR), a bridge_state_e enum, and a size_of(DATA_W) function.
- No sub-module. The write channel-pair tracker is inline.
- The CPU wrapper instantiates two copies: MID=0 for IM with BURST_LEN as configured, MID=1 for DM with BURST_LEN=1.

## Test plan
- BURST_LEN=1 read: A=0x1004, ARREADY after 2 cycles, RDATA=0xDEADBEEF → ARADDR=0x1004, ARLEN=0, DO=0xDEADBEEF, one rDone, Stall high until DONE.
- BURST_LEN=4 read: A=0x2008, beats 0x11/0x22/0x33/0x44 with a 1-cycle RVALID gap → ARADDR=0x2000, ARLEN=3, DO=0x33, LINE={44,33,22,11}.
- Write: WEB=4'b1100, DI=0x12345678, A=0x3000. Run once with AWREADY before WREADY and once in reverse → WSTRB=4'b0011, WLAST=1, no duplicate handshakes, rDone after BVALID.
- Errors: RRESP=2'b10 on the last beat → Err=1 with rDone. The next clean read → Err=0.
- Reset: assert rst=0 mid-burst (beat 2 of 4) → all outputs at reset values in the same cycle. After release, a fresh read completes normally.
- Simultaneous OE and write → write path taken; no ARVALID issued.
